// File: rtl/gba_cart_rom_reader.sv
// Serves 16-bit cart ROM fetches from a byte-wide SDRAM read port, with a one-entry
// sequential prefetch buffer and open-bus data returned beyond the loaded image.
module gba_cart_rom_reader #(
    parameter int ADDR_W   = 25,
    parameter bit PREFETCH = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              downloading,
    input  logic [ADDR_W:0]   rom_bytes,
    input  logic              req,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_seq,
    output logic              ack,
    output logic [15:0]       rdata,
    output logic              busy,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [7:0]        mem_dout
);

    // FAST pads open-bus and buffer hits so that ack lands two cycles after req.
    typedef enum logic [2:0] {IDLE, FAST, RD_LO, RD_HI, ACK, PF_LO, PF_HI} state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   a_reg;
    logic [ADDR_W-1:0]   pf_addr_reg;
    logic [15:0]         pf_data_reg;
    logic                pf_valid_reg;
    logic [7:0]          lo_reg;
    logic                pend_valid_reg;
    logic [ADDR_W-1:0]   pend_addr_reg;
    logic                pend_seq_reg;
    logic                issued_reg;
    logic                stale_reg;

    logic                take;
    logic [ADDR_W-1:0]   req_a;
    logic                np_valid;
    logic [ADDR_W-1:0]   np_addr;
    logic                np_seq;
    logic                np_match;
    logic                open_bus;
    logic                pf_hit;
    logic [ADDR_W-1:0]   a_inc1;
    logic [ADDR_W-1:0]   a_inc2;
    logic [ADDR_W-1:0]   pf_inc1;
    logic                pf_ok;
    logic                stale_eff;
    logic                got;
    logic                unused_bits;

    assign unused_bits = req_addr[0];

    always_comb begin
        take      = req & ~downloading & ~busy;
        req_a     = {req_addr[ADDR_W-1:1], 1'b0};
        np_valid  = pend_valid_reg | take;
        np_addr   = pend_valid_reg ? pend_addr_reg : req_a;
        np_seq    = pend_valid_reg ? pend_seq_reg : req_seq;
        np_match  = np_valid & np_seq & (np_addr == pf_addr_reg);
        open_bus  = ({1'b0, np_addr} >= rom_bytes);
        pf_hit    = np_seq & pf_valid_reg & (np_addr == pf_addr_reg);
        a_inc1    = a_reg + ADDR_W'(1);
        a_inc2    = a_reg + ADDR_W'(2);
        pf_inc1   = pf_addr_reg + ADDR_W'(1);
        pf_ok     = PREFETCH && ({1'b0, a_inc2} < rom_bytes);
        // A read abandoned by a download abort still owes us one mem_valid.
        stale_eff = stale_reg & ~mem_valid;
        got       = issued_reg & mem_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            a_reg          <= '0;
            pf_addr_reg    <= '0;
            pf_data_reg    <= '0;
            pf_valid_reg   <= 1'b0;
            lo_reg         <= '0;
            pend_valid_reg <= 1'b0;
            pend_addr_reg  <= '0;
            pend_seq_reg   <= 1'b0;
            issued_reg     <= 1'b0;
            stale_reg      <= 1'b0;
            ack            <= 1'b0;
            rdata          <= '0;
            busy           <= 1'b0;
            mem_rd         <= 1'b0;
            mem_addr       <= '0;
        end else begin
            ack    <= 1'b0;
            mem_rd <= 1'b0;
            if (mem_valid)
                stale_reg <= 1'b0;

            if (downloading) begin
                state_reg      <= IDLE;
                pf_valid_reg   <= 1'b0;
                pend_valid_reg <= 1'b0;
                busy           <= 1'b0;
                issued_reg     <= 1'b0;
                if (issued_reg & ~mem_valid)
                    stale_reg <= 1'b1;
            end else begin
                // Outside IDLE a request can only arrive while busy is low: ACK or prefetch.
                if (take && state_reg != IDLE) begin
                    pend_valid_reg <= 1'b1;
                    pend_addr_reg  <= req_a;
                    pend_seq_reg   <= req_seq;
                    busy           <= 1'b1;
                end

                case (state_reg)
                    IDLE: begin
                        if (np_valid) begin
                            a_reg          <= np_addr;
                            busy           <= 1'b1;
                            pend_valid_reg <= 1'b0;
                            if (open_bus) begin
                                rdata     <= np_addr[16:1];
                                state_reg <= FAST;
                            end else if (pf_hit) begin
                                rdata        <= pf_data_reg;
                                pf_valid_reg <= 1'b0;
                                state_reg    <= FAST;
                            end else begin
                                pf_valid_reg <= 1'b0;
                                state_reg    <= RD_LO;
                                issued_reg   <= ~stale_eff;
                                mem_rd       <= ~stale_eff;
                                mem_addr     <= np_addr;
                            end
                        end
                    end
                    FAST: begin
                        ack       <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= ACK;
                    end
                    RD_LO: begin
                        if (!issued_reg && !stale_reg) begin
                            issued_reg <= 1'b1;
                            mem_rd     <= 1'b1;
                            mem_addr   <= a_reg;
                        end else if (got) begin
                            lo_reg     <= mem_dout;
                            state_reg  <= RD_HI;
                            issued_reg <= 1'b1;
                            mem_rd     <= 1'b1;
                            mem_addr   <= a_inc1;
                        end
                    end
                    RD_HI: begin
                        if (!issued_reg && !stale_reg) begin
                            issued_reg <= 1'b1;
                            mem_rd     <= 1'b1;
                            mem_addr   <= a_inc1;
                        end else if (got) begin
                            rdata      <= {mem_dout, lo_reg};
                            ack        <= 1'b1;
                            busy       <= 1'b0;
                            issued_reg <= 1'b0;
                            state_reg  <= ACK;
                        end
                    end
                    ACK: begin
                        if (take) begin
                            state_reg <= IDLE;
                        end else if (pf_ok) begin
                            pf_addr_reg  <= a_inc2;
                            pf_valid_reg <= 1'b0;
                            state_reg    <= PF_LO;
                            issued_reg   <= ~stale_eff;
                            mem_rd       <= ~stale_eff;
                            mem_addr     <= a_inc2;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                    PF_LO: begin
                        if (np_valid && !np_match && !issued_reg) begin
                            state_reg <= IDLE;
                        end else if (!issued_reg && !stale_reg) begin
                            issued_reg <= 1'b1;
                            mem_rd     <= 1'b1;
                            mem_addr   <= pf_addr_reg;
                        end else if (got) begin
                            issued_reg <= 1'b0;
                            if (np_valid && !np_match) begin
                                state_reg <= IDLE;
                            end else begin
                                lo_reg     <= mem_dout;
                                state_reg  <= PF_HI;
                                issued_reg <= 1'b1;
                                mem_rd     <= 1'b1;
                                mem_addr   <= pf_inc1;
                            end
                        end
                    end
                    PF_HI: begin
                        if (np_valid && !np_match && !issued_reg) begin
                            state_reg <= IDLE;
                        end else if (!issued_reg && !stale_reg) begin
                            issued_reg <= 1'b1;
                            mem_rd     <= 1'b1;
                            mem_addr   <= pf_inc1;
                        end else if (got) begin
                            issued_reg <= 1'b0;
                            if (np_match) begin
                                // Pending sequential fetch is exactly this prefetch: serve it directly.
                                rdata          <= {mem_dout, lo_reg};
                                ack            <= 1'b1;
                                busy           <= 1'b0;
                                a_reg          <= pf_addr_reg;
                                pend_valid_reg <= 1'b0;
                                state_reg      <= ACK;
                            end else if (np_valid) begin
                                state_reg <= IDLE;
                            end else begin
                                pf_data_reg  <= {mem_dout, lo_reg};
                                pf_valid_reg <= 1'b1;
                                state_reg    <= IDLE;
                            end
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gba_cart_rom_reader.sv
// Self-checking bench: SDRAM byte responder with random latency and a behavioural
// halfword/open-bus reference model.
module tb_gba_cart_rom_reader;

    localparam int AW = 25;

    logic          clk = 1'b0;
    logic          reset;
    logic          downloading;
    logic [AW:0]   rom_bytes;
    logic          req;
    logic [AW-1:0] req_addr;
    logic          req_seq;
    logic          ack;
    logic [15:0]   rdata;
    logic          busy;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic          mem_valid;
    logic [7:0]    mem_dout;

    logic [7:0] mem [0:1023];
    int lat_min = 1;
    int lat_max = 1;
    int rd_log[$];
    int outstanding_err = 0;
    int ack_count = 0;
    int n_cmp = 0;
    int n_fail = 0;

    gba_cart_rom_reader #(.ADDR_W(AW), .PREFETCH(1'b1)) dut (
        .clk(clk), .reset(reset), .downloading(downloading), .rom_bytes(rom_bytes),
        .req(req), .req_addr(req_addr), .req_seq(req_seq),
        .ack(ack), .rdata(rdata), .busy(busy),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ack === 1'b1) ack_count++;

    // SDRAM byte port: one read at a time, answered after lat_min..lat_max cycles.
    initial begin
        logic pend_r;
        logic new_rd;
        int cnt;
        logic [AW-1:0] raddr;
        pend_r = 1'b0; cnt = 0; raddr = '0;
        mem_valid = 1'b0; mem_dout = 8'h00;
        forever begin
            @(negedge clk);
            new_rd = (mem_rd === 1'b1);
            if (new_rd && pend_r) outstanding_err++;
            mem_valid = 1'b0;
            if (pend_r) begin
                cnt--;
                if (cnt <= 0) begin
                    mem_valid = 1'b1;
                    mem_dout  = mem[raddr[9:0]];
                    pend_r    = 1'b0;
                end
            end
            if (new_rd) begin
                pend_r = 1'b1;
                raddr  = mem_addr;
                cnt    = $urandom_range(lat_min, lat_max);
                rd_log.push_back(int'(mem_addr));
            end
        end
    end

    function automatic logic [15:0] model(input logic [AW-1:0] addr);
        logic [AW-1:0] a;
        logic [AW-1:0] a1;
        a  = {addr[AW-1:1], 1'b0};
        a1 = a + 1;
        if ({1'b0, a} >= rom_bytes) return a[16:1];
        return {mem[a1[9:0]], mem[a[9:0]]};
    endfunction

    task automatic do_req(input logic [AW-1:0] addr, input logic seq,
                          output logic ok, output logic [15:0] data, output int cycles);
        int w;
        w = 0; ok = 1'b0; data = '0; cycles = 0;
        while (busy && w < 400) begin @(negedge clk); w++; end
        req = 1'b1; req_addr = addr; req_seq = seq;
        @(negedge clk);
        req = 1'b0;
        cycles = 1;
        while (!ack && cycles < 400) begin @(negedge clk); cycles++; end
        if (ack) begin ok = 1'b1; data = rdata; end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; downloading = 1'b0; req = 1'b0; req_addr = '0; req_seq = 1'b0;
        rom_bytes = 26'd16;
        idle_cycles(4);
        n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", ack); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd got %b want 0", mem_rd); end
        n_cmp++; if (rdata !== 16'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0000", rdata); end
        n_cmp++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        reset = 1'b0;
        idle_cycles(2);
        $display("reset released");
    endtask

    task automatic test_miss;
        logic ok; logic [15:0] d; int c; int base;
        lat_min = 3; lat_max = 3;
        base = rd_log.size();
        do_req(25'h4, 1'b0, ok, d, c);
        n_cmp++; if (!ok || d !== 16'h1514) begin n_fail++; $display("FAIL miss_rdata got %h ok=%b want 1514", d, ok); end
        n_cmp++;
        if (rd_log.size() < base + 2 || rd_log[base] != 4 || rd_log[base+1] != 5) begin
            n_fail++; $display("FAIL miss_reads got %0d reads, first %0d want 4,5", rd_log.size() - base,
                               (rd_log.size() > base) ? rd_log[base] : -1);
        end
        $display("miss a=0x4 rdata=%h cycles=%0d", d, c);
    endtask

    task automatic test_prefetch_hit;
        logic ok; logic [15:0] d; int c; int n;
        idle_cycles(40);
        n = rd_log.size();
        n_cmp++;
        if (n < 2 || rd_log[n-2] != 6 || rd_log[n-1] != 7) begin
            n_fail++; $display("FAIL prefetch_reads got last %0d want 6,7", (n > 0) ? rd_log[n-1] : -1);
        end
        do_req(25'h6, 1'b1, ok, d, c);
        n_cmp++; if (!ok || d !== 16'h1716) begin n_fail++; $display("FAIL hit_rdata got %h want 1716", d); end
        n_cmp++; if (c != 2) begin n_fail++; $display("FAIL hit_latency got %0d want 2", c); end
        n_cmp++; if (rd_log.size() != n) begin n_fail++; $display("FAIL hit_no_read got %0d reads want 0", rd_log.size() - n); end
        $display("hit a=0x6 rdata=%h cycles=%0d", d, c);
    endtask

    task automatic test_open_bus;
        logic ok; logic [15:0] d; int c; int n;
        idle_cycles(40);
        n = rd_log.size();
        do_req(25'h20, 1'b0, ok, d, c);
        idle_cycles(2);
        n_cmp++; if (!ok || d !== 16'h0010) begin n_fail++; $display("FAIL open_rdata got %h want 0010", d); end
        n_cmp++; if (c != 2) begin n_fail++; $display("FAIL open_latency got %0d want 2", c); end
        n_cmp++; if (rd_log.size() != n) begin n_fail++; $display("FAIL open_no_read got %0d reads want 0", rd_log.size() - n); end
        $display("open a=0x20 rdata=%h cycles=%0d", d, c);
    endtask

    task automatic test_req_during_prefetch;
        logic ok; logic [15:0] d; int c; int w; int pos;
        lat_min = 10; lat_max = 10;
        do_req(25'h4, 1'b0, ok, d, c);
        w = 0;
        while (!(mem_rd === 1'b1 && mem_addr == 25'h6) && w < 100) begin @(negedge clk); w++; end
        n_cmp++; if (w >= 100) begin n_fail++; $display("FAIL pf_start got none want read 6"); end
        do_req(25'h0, 1'b0, ok, d, c);
        n_cmp++; if (!ok || d !== 16'h1110) begin n_fail++; $display("FAIL pf_abort_rdata got %h want 1110", d); end
        pos = -1;
        foreach (rd_log[i]) if (rd_log[i] == 6) pos = i;
        n_cmp++;
        if (pos < 0 || rd_log.size() != pos + 3 || rd_log[pos+1] != 0 || rd_log[pos+2] != 1) begin
            n_fail++; $display("FAIL pf_abort_reads got %0d reads after 6 want 0,1", rd_log.size() - pos - 1);
        end
        $display("pending a=0x0 during prefetch rdata=%h cycles=%0d", d, c);
    endtask

    task automatic test_download_abort;
        logic ok; logic [15:0] d; int c; int w; int a0;
        lat_min = 5; lat_max = 5;
        idle_cycles(60);
        req = 1'b1; req_addr = 25'h8; req_seq = 1'b0;
        @(negedge clk); req = 1'b0;
        w = 0;
        while (!(mem_rd === 1'b1 && mem_addr == 25'h9) && w < 100) begin @(negedge clk); w++; end
        a0 = ack_count;
        downloading = 1'b1;
        idle_cycles(3);
        req = 1'b1; req_addr = 25'h2; req_seq = 1'b0;
        @(negedge clk); req = 1'b0;
        idle_cycles(8);
        n_cmp++; if (ack_count != a0) begin n_fail++; $display("FAIL dl_no_ack got %0d acks want 0", ack_count - a0); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dl_busy got %b want 0", busy); end
        downloading = 1'b0;
        idle_cycles(20);
        n_cmp++; if (ack_count != a0) begin n_fail++; $display("FAIL dl_late_ack got %0d acks want 0", ack_count - a0); end
        do_req(25'hA, 1'b0, ok, d, c);
        n_cmp++; if (!ok || d !== 16'h1B1A) begin n_fail++; $display("FAIL dl_after_rdata got %h want 1b1a", d); end
        $display("download abort, then a=0xA rdata=%h cycles=%0d", d, c);
    endtask

    task automatic test_boundaries;
        logic ok; logic [15:0] d; int c;
        lat_min = 2; lat_max = 4;
        idle_cycles(40);
        rom_bytes = 26'd15;
        do_req(25'hE, 1'b0, ok, d, c);
        n_cmp++; if (!ok || d !== 16'h1F1E) begin n_fail++; $display("FAIL odd_rom_rdata got %h want 1f1e", d); end
        $display("odd rom a=0xE rdata=%h", d);
        idle_cycles(40);
        rom_bytes = 26'd0;
        do_req(25'h1, 1'b0, ok, d, c);
        n_cmp++; if (!ok || d !== 16'h0000 || c != 2) begin n_fail++; $display("FAIL empty_rom got %h/%0d want 0000/2", d, c); end
        $display("empty rom a=0x1 rdata=%h cycles=%0d", d, c);
    endtask

    task automatic test_random;
        logic ok; logic [15:0] d; logic [15:0] exp; int c; int a0; int shown;
        logic seq; logic [AW-1:0] addr; logic [AW-1:0] prev;
        lat_min = 1; lat_max = 20;
        idle_cycles(60);
        downloading = 1'b1;
        rom_bytes = 26'($urandom_range(1, 600));
        foreach (mem[i]) mem[i] = 8'($urandom);
        idle_cycles(4);
        downloading = 1'b0;
        idle_cycles(40);
        a0 = ack_count; shown = 0; prev = '0;
        for (int i = 0; i < 1000; i++) begin
            seq = (i > 0) && ($urandom_range(0, 1) == 1);
            if (seq) addr = prev + 2;
            else addr = AW'($urandom_range(0, int'(rom_bytes) + 40));
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(0, 30));
            exp = model(addr);
            do_req(addr, seq, ok, d, c);
            n_cmp++;
            if (!ok || d !== exp) begin
                n_fail++;
                if (shown < 20) $display("FAIL rand_rdata #%0d a=%h got %h ok=%b want %h", i, addr, d, ok, exp);
                shown++;
            end
            prev = {addr[AW-1:1], 1'b0};
        end
        idle_cycles(60);
        n_cmp++; if (ack_count - a0 != 1000) begin n_fail++; $display("FAIL rand_ack_count got %0d want 1000", ack_count - a0); end
        n_cmp++; if (outstanding_err != 0) begin n_fail++; $display("FAIL one_outstanding got %0d overlaps want 0", outstanding_err); end
        $display("random: 1000 fetches, rom_bytes=%0d", rom_bytes);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'(8'h10 + i);
        test_reset;
        test_miss;
        test_prefetch_hit;
        test_open_bus;
        test_req_during_prefetch;
        test_download_abort;
        test_boundaries;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
